exec_flags: RTL

Execute-stage flag register and branch resolver that sits directly downstream of the 16-bit ALU. It registers the ALU result into the EX/MEM boundary, and commits {neg, ov, zr} to an architectural flag register using per-opcode update masks. It also resolves conditional branches against those flags, forwarding same-cycle updates. Stall and flush come from the hazard unit.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/exec_flags_branch_cond.sv | 17 +
 rtl/exec_flags.sv | 57 +++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, branch condition codes and flag bit indices shared by ALU, decoder and EX stage
package cpu_pkg;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_PADDSB = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;
    localparam logic [2:0] CC_NE = 3'b000;
    localparam logic [2:0] CC_EQ = 3'b001;
    localparam logic [2:0] CC_GT = 3'b010;
    localparam logic [2:0] CC_LT = 3'b011;
    localparam logic [2:0] CC_GE = 3'b100;
    localparam logic [2:0] CC_LE = 3'b101;
    localparam logic [2:0] CC_OV = 3'b110;
    localparam logic [2:0] CC_ALW = 3'b111;
    localparam int FLAG_NEG = 2;
    localparam int FLAG_OV = 1;
    localparam int FLAG_ZR = 0;
endpackage

// File: rtl/exec_flags_branch_cond.sv
// branch_cond: maps a condition code and {neg, ov, zr} flags to a taken decision
module branch_cond
    import cpu_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       taken
);
    logic neg, ov, zr;
    logic [7:0] table_by_cc;
    assign neg = flags[FLAG_NEG];
    assign ov = flags[FLAG_OV];
    assign zr = flags[FLAG_ZR];
    // bit i holds the outcome of condition code i
    assign table_by_cc = {1'b1, ov, neg | zr, ~neg, neg, ~zr & ~neg, zr, ~zr};
    assign taken = table_by_cc[cond];
endmodule

// File: rtl/exec_flags.sv
// exec_flags: EX/MEM result register, masked flag commit and branch resolution on forwarded flags
module exec_flags
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [2:0]  alu_op,
    input  logic [15:0] alu_result,
    input  logic [2:0]  alu_flags,
    input  logic        br_valid,
    input  logic [2:0]  br_cond,
    input  logic        stall,
    input  logic        flush,
    output logic        ex_valid,
    output logic [15:0] ex_result,
    output logic [2:0]  flags_q,
    output logic        br_resolved,
    output logic        br_taken
);
    logic       fire;
    logic       taken;
    logic [2:0] op_mask;
    logic [2:0] mask;
    logic [2:0] flags_next;
    assign fire = alu_valid & ~stall & ~flush;
    assign op_mask = (alu_op == OP_ADD || alu_op == OP_SUB) ? 3'b111 :
                     (alu_op == OP_PADDSB) ? 3'b000 : 3'b001;
    assign mask = fire ? op_mask : 3'b000;
    // same-cycle ALU op is older than the branch, so branches see the forwarded flags
    assign flags_next = (flags_q & ~mask) | (alu_flags & mask);
    branch_cond u_branch_cond (
        .cond  (br_cond),
        .flags (flags_next),
        .taken (taken)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_result <= 16'h0000;
            flags_q <= 3'b000;
            br_resolved <= 1'b0;
            br_taken <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            br_resolved <= 1'b0;
            br_taken <= 1'b0;
        end else if (!stall) begin
            ex_valid <= alu_valid;
            if (alu_valid)
                ex_result <= alu_result;
            flags_q <= flags_next;
            br_resolved <= br_valid;
            br_taken <= br_valid & taken;
        end
    end
endmodule
